// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU; single-cycle ops, iterative shift-add multiply, optional divide (SEQ_ALU_DIV_EN).
// Latency: single ops valid one cycle after accept, mul after WIDTH edges, div after WIDTH+1 edges.
// Backpressure: ready_o only in IDLE; a result is held in DONE until ready_i, stalling new operations.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [3:0]       ALUCtrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             busy_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DONE = 3'd2;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DFIX = 3'd4;
`endif

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_REM = 4'b1011;
`endif

  logic [2:0]       state;
  logic [SHW-1:0]   cnt;
  // acc: product accumulator / partial remainder
  // opa: multiplier (shifts right) / dividend-then-quotient (shifts left)
  // opb: multiplicand (shifts left) / divisor magnitude
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             zero;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] acc_mul_nxt;

  assign shamt   = data2_i[SHW-1:0];
  assign ready_o = (state == S_IDLE);
  assign valid_o = (state == S_DONE);
  assign data_o  = res;
  assign Zero_o  = zero;
`ifdef SEQ_ALU_DIV_EN
  assign busy_o  = (state == S_MUL) || (state == S_DIV) || (state == S_DFIX);
`else
  assign busy_o  = (state == S_MUL);
`endif

  // Single-cycle result computed straight from the input operands at accept
  always_comb begin
    single_res = '0;
    case (ALUCtrl_i)
      OP_ADD:  single_res = data1_i + data2_i;
      OP_SUB:  single_res = data1_i - data2_i;
      OP_AND:  single_res = data1_i & data2_i;
      OP_XOR:  single_res = data1_i ^ data2_i;
      OP_OR:   single_res = data1_i | data2_i;
      OP_SLL:  single_res = data1_i << shamt;
      OP_SRL:  single_res = data1_i >> shamt;
      OP_SRA:  single_res = $signed(data1_i) >>> shamt;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      default: single_res = '0;
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier bit is set
  always_comb begin
    acc_mul_nxt = acc + (opa[0] ? opb : '0);
  end

`ifdef SEQ_ALU_DIV_EN
  logic             a_neg, q_neg, b_zero, div_rem;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             take;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, fix_res;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned
  always_comb begin
    a_mag = data1_i[WIDTH-1] ? (~data1_i + 1'b1) : data1_i;
    b_mag = data2_i[WIDTH-1] ? (~data2_i + 1'b1) : data2_i;
  end

  // Restoring divide step; the partial remainder never reaches bit WIDTH-1 before
  // shifting, so a WIDTH-bit shifted remainder is enough
  always_comb begin
    rem_shift = {acc[WIDTH-2:0], opa[WIDTH-1]};
    rem_diff  = {1'b0, rem_shift} - {1'b0, opb};
    take      = ~rem_diff[WIDTH];
    rem_nxt   = take ? rem_diff[WIDTH-1:0] : rem_shift;
    quo_nxt   = {opa[WIDTH-2:0], take};
  end

  // Sign fix: quotient negative when signs differ, remainder follows dividend;
  // divide by zero forces all-ones quotient (remainder naturally equals dividend)
  always_comb begin
    if (div_rem)
      fix_res = a_neg ? (~acc + 1'b1) : acc;
    else if (b_zero)
      fix_res = '1;
    else
      fix_res = q_neg ? (~opa + 1'b1) : opa;
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      zero  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      a_neg   <= 1'b0;
      q_neg   <= 1'b0;
      b_zero  <= 1'b0;
      div_rem <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            cnt <= '0;
            if (ALUCtrl_i == OP_MUL) begin
              state <= S_MUL;
              acc   <= '0;
              opa   <= data2_i;
              opb   <= data1_i;
`ifdef SEQ_ALU_DIV_EN
            end else if (ALUCtrl_i == OP_DIV || ALUCtrl_i == OP_REM) begin
              state   <= S_DIV;
              acc     <= '0;
              opa     <= a_mag;
              opb     <= b_mag;
              a_neg   <= data1_i[WIDTH-1];
              q_neg   <= data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
              b_zero  <= (data2_i == '0);
              div_rem <= (ALUCtrl_i == OP_REM);
`endif
            end else begin
              state <= S_DONE;
              res   <= single_res;
              zero  <= (single_res == '0);
            end
          end
        end
        S_MUL: begin
          acc <= acc_mul_nxt;
          opa <= opa >> 1;
          opb <= opb << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            res   <= acc_mul_nxt;
            zero  <= (acc_mul_nxt == '0);
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          acc <= rem_nxt;
          opa <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= S_DFIX;
        end
        S_DFIX: begin
          state <= S_DONE;
          res   <= fix_res;
          zero  <= (fix_res == '0);
        end
`endif
        S_DONE: begin
          if (ready_i)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus random ops against a
// behavioural model built from plain signed/unsigned arithmetic.
module tb_seq_alu;

  localparam int W   = 32;
  localparam int SHW = $clog2(W);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] data2 = '0;
  logic [3:0]   ctrl = '0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] data_o;
  logic         zero_o;
  logic         busy_o;

  int checks = 0;
  int failures = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data1_i(data1), .data2_i(data2), .ALUCtrl_i(ctrl), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .Zero_o(zero_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference result straight from the opcode table
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [SHW-1:0]      sh;
    logic [W-1:0]        minv;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    minv = {1'b1, {(W-1){1'b0}}};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a ^ b;
      4'd4: return a * b;
      4'd5: return a << sh;
      4'd6: return sa >>> sh;
      4'd7: return a | b;
      4'd8: return a >> sh;
      4'd9: return (sa < sb) ? 1 : 0;
`ifdef SEQ_ALU_DIV_EN
      4'd10: begin
        if (b == 0) return '1;
        if (a == minv && b == '1) return a;
        return sa / sb;
      end
      4'd11: begin
        if (b == 0) return a;
        if (a == minv && b == '1) return '0;
        return sa % sb;
      end
`endif
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    if (op == 4'd4) return W;
`ifdef SEQ_ALU_DIV_EN
    if (op == 4'd10 || op == 4'd11) return W + 1;
`endif
    return 0;
  endfunction

  // Called at a negedge with the DUT idle; issues one op, checks latency, busy
  // time, result, Zero_o, holds the result for 'stall' cycles, then releases it
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    logic [W-1:0] exp;
    int e, busy_cnt, k;
    bit seen;
    exp = model(op, a, b);
    chk({tag, ".ready"}, ready_o, 1);
    ctrl = op; data1 = a; data2 = b; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    e = -1; busy_cnt = 0; k = 0; seen = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      if (valid_o) begin
        seen = 1;
        e = k;
      end else if (busy_o) begin
        busy_cnt++;
      end
      k++;
    end
    chk({tag, ".valid_seen"}, seen, 1);
    chk({tag, ".latency"}, e, model_lat(op));
    chk({tag, ".busy_cycles"}, busy_cnt, model_lat(op));
    chk({tag, ".data"}, data_o, exp);
    chk({tag, ".zero"}, zero_o, exp == '0);
    for (int s = 0; s < stall; s++) begin
      // a new operation offered while the result is pending must be ignored
      ctrl = 4'd0; data1 = 1; data2 = 1; valid_i = (s == 0);
      @(negedge clk);
      valid_i = 1'b0;
      chk({tag, ".hold_valid"}, valid_o, 1);
      chk({tag, ".hold_data"}, data_o, exp);
      chk({tag, ".hold_zero"}, zero_o, exp == '0);
      chk({tag, ".hold_ready"}, ready_o, 0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk({tag, ".released"}, valid_o, 0);
    chk({tag, ".idle_ready"}, ready_o, 1);
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;

    // Reset with valid_i asserted: must be ignored
    valid_i = 1'b1; ctrl = 4'd0; data1 = 5; data2 = 6;
    repeat (3) @(negedge clk);
    chk("rst.ready", ready_o, 1);
    chk("rst.valid", valid_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.data", data_o, 0);
    chk("rst.zero", zero_o, 0);
    valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.valid", valid_o, 0);

    // Directed cases
    run_op("add7m3", 4'd0, 32'd7, -32'sd3, 0);
    run_op("sub55", 4'd1, 32'd5, 32'd5, 3);
    run_op("mul_m1x3", 4'd4, 32'hFFFF_FFFF, 32'd3, 0);
    chk("mul_m1x3.const", model(4'd4, 32'hFFFF_FFFF, 32'd3), 32'hFFFF_FFFD);
    run_op("sra", 4'd6, 32'h8000_0000, 32'h0000_0024, 0);
    run_op("srl", 4'd8, 32'h8000_0000, 32'h0000_0024, 1);
    run_op("sll", 4'd5, 32'h0000_0001, 32'h0000_003F, 0);
    run_op("slt_m1_1", 4'd9, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt_1_m1", 4'd9, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("mul_zero", 4'd4, 32'd12345, 32'd0, 2);
    run_op("undef15", 4'd15, 32'd9, 32'd9, 0);
    run_op("div_m7_2", 4'd10, -32'sd7, 32'd2, 0);
    run_op("rem_m7_2", 4'd11, -32'sd7, 32'd2, 0);
    run_op("div_5_0", 4'd10, 32'd5, 32'd0, 0);
    run_op("rem_m5_0", 4'd11, -32'sd5, 32'd0, 0);
    run_op("div_ovf", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1);

    // Reset in the middle of a multiply
    ctrl = 4'd4; data1 = 32'd1234; data2 = 32'd5678; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst.busy_before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy_o, 0);
    chk("midrst.valid", valid_o, 0);
    chk("midrst.ready", ready_o, 1);
    chk("midrst.data", data_o, 0);
    chk("midrst.zero", zero_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("add_after_rst", 4'd0, 32'd1, 32'd1, 0);

    // Random operations, biased toward corner operands
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = '1;
        2: ra = {1'b1, {(W-1){1'b0}}};
        3: ra = rb;
        default: ;
      endcase
      run_op("rand", rop, ra, rb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
